// File: rtl/spinner_mc.sv
// Multi-channel spinner position tracker: per-channel accumulators driven by
// strobe-gated digital steps plus toggle-signalled analog (spinner/mouse) deltas.
module spinner_mc #(
    parameter int NCH       = 2,
    parameter int OUT_W     = 8,
    parameter int STEP_SLOW = 1,
    parameter int STEP_FAST = 4,
    parameter int CLAMP     = 0,
    parameter int INIT      = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   strobe,
    input  logic [NCH-1:0]         minus,
    input  logic [NCH-1:0]         plus,
    input  logic [NCH-1:0]         fast,
    input  logic [NCH*9-1:0]       spin_in,
    input  logic [8:0]             mouse_in,
    output logic [NCH*OUT_W-1:0]   spin_out,
    output logic [NCH-1:0]         moved,
    output logic                   src_mouse
);

    localparam int SUM_W = OUT_W + 2;
    localparam logic [OUT_W-1:0]        INIT_V = OUT_W'(INIT);
    localparam logic signed [SUM_W-1:0] STEP_S = SUM_W'(STEP_SLOW);
    localparam logic signed [SUM_W-1:0] STEP_F = SUM_W'(STEP_FAST);

    logic             strobe_s;
    logic             strobe_d;
    logic [NCH-1:0]   plus_s;
    logic [NCH-1:0]   minus_s;
    logic [NCH-1:0]   fast_s;
    logic [8:0]       spin_s [NCH];
    logic [NCH-1:0]   spin_h;
    logic [8:0]       mouse_s;
    logic             mouse_h;
    logic             samp_valid;
    logic             primed;

    logic [OUT_W-1:0] pos     [NCH];
    logic [OUT_W-1:0] pos_nxt [NCH];
    logic [NCH-1:0]   moved_nxt;
    logic             src_nxt;

    logic             strobe_edge;
    logic             mouse_evt;
    logic [NCH-1:0]   spin_evt;

    function automatic logic signed [SUM_W-1:0] sext8(input logic [7:0] d);
        return SUM_W'($signed(d));
    endfunction

    function automatic logic [OUT_W-1:0] fit(input logic signed [SUM_W-1:0] s);
        if (CLAMP == 0)
            return s[OUT_W-1:0];
        else if (s[SUM_W-1])
            return '0;
        else if (|s[SUM_W-2:OUT_W])
            return '1;
        else
            return s[OUT_W-1:0];
    endfunction

    // Toggle histories only count once a real sample has reached them (primed).
    always_comb begin
        strobe_edge = strobe_s & ~strobe_d;
        mouse_evt   = primed & (mouse_s[8] ^ mouse_h);
        spin_evt    = '0;
        for (int i = 0; i < NCH; i++)
            spin_evt[i] = primed & (spin_s[i][8] ^ spin_h[i]);
        if (spin_evt[0])
            src_nxt = 1'b0;
        else if (mouse_evt)
            src_nxt = 1'b1;
        else
            src_nxt = src_mouse;
    end

    always_comb begin
        logic signed [SUM_W-1:0] step;
        logic signed [SUM_W-1:0] dig;
        logic signed [SUM_W-1:0] ana;
        logic signed [SUM_W-1:0] sum;
        step      = '0;
        dig       = '0;
        ana       = '0;
        sum       = '0;
        moved_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            step = fast_s[i] ? STEP_F : STEP_S;
            dig  = '0;
            if (strobe_edge && plus_s[i] && !minus_s[i])
                dig = step;
            else if (strobe_edge && minus_s[i] && !plus_s[i])
                dig = -step;
            ana = '0;
            // Channel 0 listens to whichever source was selected at the start of the cycle.
            if (i == 0 && src_mouse) begin
                if (mouse_evt)
                    ana = sext8(mouse_s[7:0]);
            end else if (spin_evt[i]) begin
                ana = sext8(spin_s[i][7:0]);
            end
            sum          = $signed({2'b00, pos[i]}) + dig + ana;
            pos_nxt[i]   = fit(sum);
            moved_nxt[i] = (pos_nxt[i] != pos[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_s   <= 1'b1;
            strobe_d   <= 1'b1;
            plus_s     <= '0;
            minus_s    <= '0;
            fast_s     <= '0;
            spin_h     <= '0;
            mouse_s    <= '0;
            mouse_h    <= 1'b0;
            samp_valid <= 1'b0;
            primed     <= 1'b0;
            src_mouse  <= 1'b0;
            moved      <= '0;
            for (int i = 0; i < NCH; i++) begin
                spin_s[i] <= '0;
                pos[i]    <= INIT_V;
            end
        end else begin
            strobe_d   <= strobe_s;
            strobe_s   <= strobe;
            plus_s     <= plus;
            minus_s    <= minus;
            fast_s     <= fast;
            mouse_h    <= mouse_s[8];
            mouse_s    <= mouse_in;
            samp_valid <= 1'b1;
            primed     <= samp_valid;
            src_mouse  <= src_nxt;
            moved      <= moved_nxt;
            for (int i = 0; i < NCH; i++) begin
                spin_h[i] <= spin_s[i][8];
                spin_s[i] <= spin_in[i*9 +: 9];
                pos[i]    <= pos_nxt[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_out
        assign spin_out[g*OUT_W +: OUT_W] = pos[g];
    end

endmodule

// File: tb/tb_spinner_mc.sv
// Scoreboard bench: a wrapping and a saturating spinner_mc share directed stimulus;
// expected position updates are queued and matched against each moved pulse.
module tb_spinner_mc;

    typedef struct {
        int ch;
        int value;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        strobe;
    logic [1:0]  minus;
    logic [1:0]  plus;
    logic [1:0]  fast;
    logic [17:0] spin_in;
    logic [8:0]  mouse_in;

    logic [15:0] out_wrap;
    logic [1:0]  moved_wrap;
    logic        src_wrap;
    logic [15:0] out_sat;
    logic [1:0]  moved_sat;
    logic        src_sat;

    exp_t q_wrap[$];
    exp_t q_sat[$];
    int   n_compared = 0;
    int   n_mismatch = 0;

    spinner_mc #(.NCH(2), .OUT_W(8), .STEP_SLOW(1), .STEP_FAST(4), .CLAMP(0), .INIT(0)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .minus(minus), .plus(plus),
        .fast(fast), .spin_in(spin_in), .mouse_in(mouse_in),
        .spin_out(out_wrap), .moved(moved_wrap), .src_mouse(src_wrap)
    );

    spinner_mc #(.NCH(2), .OUT_W(8), .STEP_SLOW(1), .STEP_FAST(4), .CLAMP(1), .INIT(0)) dut_sat (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .minus(minus), .plus(plus),
        .fast(fast), .spin_in(spin_in), .mouse_in(mouse_in),
        .spin_out(out_sat), .moved(moved_sat), .src_mouse(src_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkMoved(input int which, input int ch, input int value);
        exp_t e;
        n_compared++;
        if ((which == 0 && q_wrap.size() == 0) || (which == 1 && q_sat.size() == 0)) begin
            n_mismatch++;
            $display("[TB] FAIL unexpected_move dut%0d ch%0d: got value %0d, expected no update",
                     which, ch, value);
        end else begin
            e = (which == 0) ? q_wrap.pop_front() : q_sat.pop_front();
            if (e.ch != ch || e.value != value) begin
                n_mismatch++;
                $display("[TB] FAIL move dut%0d: got ch%0d=%0d, expected ch%0d=%0d",
                         which, ch, value, e.ch, e.value);
            end
        end
    endtask

    task automatic expectMove(input int which, input int ch, input int value);
        exp_t e;
        e.ch    = ch;
        e.value = value;
        if (which == 0) q_wrap.push_back(e);
        else            q_sat.push_back(e);
    endtask

    task automatic toggleSpin(input int ch, input logic [7:0] delta);
        spin_in[ch*9 +: 9] = {~spin_in[ch*9 + 8], delta};
    endtask

    task automatic toggleMouse(input logic [7:0] delta);
        mouse_in = {~mouse_in[8], delta};
    endtask

    // One stimulus frame: optional one-cycle strobe pulse, then enough idle cycles to retire it.
    task automatic applyStimulus(input logic do_strobe, input logic [1:0] p,
                                 input logic [1:0] m, input logic [1:0] f);
        plus   = p;
        minus  = m;
        fast   = f;
        strobe = do_strobe;
        tick(1);
        strobe = 1'b0;
        tick(3);
        plus  = '0;
        minus = '0;
    endtask

    // Monitor: every moved pulse must match the head of that DUT's expectation queue.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (moved_wrap[ch]) checkMoved(0, ch, int'(out_wrap[ch*8 +: 8]));
                if (moved_sat[ch])  checkMoved(1, ch, int'(out_sat[ch*8 +: 8]));
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        strobe   = 1'b1;
        plus     = '0;
        minus    = '0;
        fast     = '0;
        spin_in  = 18'h00100;
        mouse_in = '0;
        tick(3);
        checkOutput("reset_out_wrap", int'(out_wrap), 0);
        checkOutput("reset_out_sat", int'(out_sat), 0);
        checkOutput("reset_moved", int'({moved_wrap, moved_sat}), 0);
        checkOutput("reset_src", int'({src_wrap, src_sat}), 0);

        // Strobe and spinner bit held high through release: no update allowed.
        reset_n = 1'b1;
        tick(3);
        checkOutput("release_hold_wrap", int'(out_wrap), 0);
        checkOutput("release_hold_sat", int'(out_sat), 0);
        strobe = 1'b0;
        tick(2);

        $display("[TB] slow plus on ch0");
        for (int n = 1; n <= 3; n++) begin
            expectMove(0, 0, n);
            expectMove(1, 0, n);
            applyStimulus(1'b1, 2'b01, 2'b00, 2'b00);
        end
        checkOutput("ch0_after_3_wrap", int'(out_wrap[7:0]), 3);
        checkOutput("ch1_idle_wrap", int'(out_wrap[15:8]), 0);
        checkOutput("ch1_idle_sat", int'(out_sat[15:8]), 0);

        $display("[TB] ch1 to 5 then analog -10");
        expectMove(0, 1, 4); expectMove(1, 1, 4);
        applyStimulus(1'b1, 2'b10, 2'b00, 2'b10);
        expectMove(0, 1, 5); expectMove(1, 1, 5);
        applyStimulus(1'b1, 2'b10, 2'b00, 2'b00);
        toggleSpin(1, 8'hF6);
        expectMove(0, 1, 251); expectMove(1, 1, 0);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        checkOutput("ch1_neg_wrap", int'(out_wrap[15:8]), 251);
        checkOutput("ch1_neg_sat", int'(out_sat[15:8]), 0);

        $display("[TB] coincident digital and analog on ch0");
        toggleSpin(0, 8'h07);
        expectMove(0, 0, 10); expectMove(1, 0, 10);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        toggleSpin(0, 8'h05);
        expectMove(0, 0, 16); expectMove(1, 0, 16);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b00);
        checkOutput("coincide_wrap", int'(out_wrap[7:0]), 16);
        checkOutput("coincide_sat", int'(out_sat[7:0]), 16);

        $display("[TB] upper boundary wrap vs saturate");
        toggleSpin(0, 8'h7F);
        expectMove(0, 0, 143); expectMove(1, 0, 143);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        toggleSpin(0, 8'h6F);
        expectMove(0, 0, 254); expectMove(1, 0, 254);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        expectMove(0, 0, 2); expectMove(1, 0, 255);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b01);
        expectMove(0, 0, 6);
        applyStimulus(1'b1, 2'b01, 2'b00, 2'b01);
        checkOutput("top_wrap", int'(out_wrap[7:0]), 6);
        checkOutput("top_sat", int'(out_sat[7:0]), 255);

        // plus and minus together cancel; minus fast wraps below zero.
        applyStimulus(1'b1, 2'b11, 2'b11, 2'b00);
        expectMove(0, 0, 2); expectMove(1, 0, 251);
        applyStimulus(1'b1, 2'b00, 2'b01, 2'b01);
        expectMove(0, 0, 254); expectMove(1, 0, 247);
        applyStimulus(1'b1, 2'b00, 2'b01, 2'b01);
        checkOutput("minus_wrap", int'(out_wrap[7:0]), 254);

        $display("[TB] mouse source selection");
        toggleMouse(8'h00);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        checkOutput("src_after_mouse_wrap", int'(src_wrap), 1);
        checkOutput("src_after_mouse_sat", int'(src_sat), 1);
        toggleMouse(8'h07);
        expectMove(0, 0, 5); expectMove(1, 0, 254);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        toggleSpin(0, 8'h02);
        toggleMouse(8'h09);
        expectMove(0, 0, 14); expectMove(1, 0, 255);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        checkOutput("src_spin_wins", int'({src_wrap, src_sat}), 0);
        toggleSpin(0, 8'h03);
        expectMove(0, 0, 17);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        toggleMouse(8'h20);
        applyStimulus(1'b0, 2'b00, 2'b00, 2'b00);
        checkOutput("mouse_discarded_wrap", int'(out_wrap[7:0]), 17);
        checkOutput("src_reselect", int'(src_wrap), 1);

        $display("[TB] async reset with pending update");
        toggleSpin(1, 8'h05);
        tick(1);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_out_wrap", int'(out_wrap), 0);
        checkOutput("midreset_out_sat", int'(out_sat), 0);
        checkOutput("midreset_src", int'({src_wrap, src_sat}), 0);
        tick(2);
        reset_n = 1'b1;
        tick(4);
        checkOutput("post_reset_wrap", int'(out_wrap), 0);

        checkOutput("q_wrap_drained", q_wrap.size(), 0);
        checkOutput("q_sat_drained", q_sat.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
